key_sched_multi: RTL and testbench

- Sequential AES key expander supporting AES-128, AES-192 and AES-256, selected per load by an input mode field.
- Generates one 32-bit expansion word per clock into an internal word store.
- Exposes round keys through an indexed, registered read port instead of a flat output array.
- Sits between the key-load interface and the round pipeline; the pipeline fetches round keys by index once keys_ready is high.

---
 rtl/aes_pkg.sv | 69 ++++++
 rtl/aes_sbox.sv | 37 +++
 rtl/key_word_gen.sv | 46 ++++
 rtl/key_sched_multi.sv | 167 ++++++++++++++++
 tb/tb_key_sched_multi.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared AES key-schedule types, key-length encodings and lookups.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } ks_state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_LEN_128: return 4'd4;
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_LEN_128: return 4'd10;
            KEY_LEN_192: return 4'd12;
            KEY_LEN_256: return 4'd14;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [5:0] nwords_of(input logic [1:0] len);
        case (len)
            KEY_LEN_128: return 6'd44;
            KEY_LEN_192: return 6'd52;
            KEY_LEN_256: return 6'd60;
            default:     return 6'd0;
        endcase
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// ============================================================================
//  Module   : aes_sbox
//  Purpose  : Combinational AES forward S-box (table lookup).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Byte x sits at bits [(255-x)*8 +: 8]; 255-x is simply ~x.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = c_SBOX[{~in_i, 3'b000} +: 8];

endmodule

`default_nettype wire

// File: rtl/key_word_gen.sv
// ============================================================================
//  Module   : key_word_gen
//  Purpose  : Combinational generation of one AES expansion word w[i].
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_word_gen
    import aes_pkg::*;
(
    input  word_t      w_prev_i,
    input  word_t      w_back_i,
    input  logic [2:0] p_i,
    input  logic [3:0] nk_i,
    input  logic [7:0] rcon_i,
    output word_t      w_new_o
);

    word_t w_sbox_in;
    word_t w_sub;
    word_t w_temp;

    // RotWord only at the start of each Nk group; the Nk==8 mid-group step substitutes unrotated.
    assign w_sbox_in = (p_i == 3'd0) ? {w_prev_i[23:0], w_prev_i[31:24]} : w_prev_i;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (w_sbox_in[8*b +: 8]),
            .out_o (w_sub[8*b +: 8])
        );
    end

    always_comb begin
        w_temp = w_prev_i;
        if (p_i == 3'd0) begin
            w_temp = w_sub ^ {rcon_i, 24'h000000};
        end else if ((nk_i == 4'd8) && (p_i == 3'd4)) begin
            w_temp = w_sub;
        end
    end

    assign w_new_o = w_back_i ^ w_temp;

endmodule

`default_nettype wire

// File: rtl/key_sched_multi.sv
// ============================================================================
//  Module   : key_sched_multi
//  Purpose  : Sequential AES-128/192/256 key expander, one word per clock,
//             round keys served through a registered indexed read port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_sched_multi
    import aes_pkg::*;
#(
    parameter int MAX_NK   = 8,
    parameter int RK_IDX_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_key,
    input  logic [1:0]          key_len,
    input  logic [255:0]        key_in,
    output logic                busy,
    output logic                keys_ready,
    output logic                key_err,
    output logic [3:0]          nr,
    input  logic [RK_IDX_W-1:0] rk_rd_idx,
    output logic [127:0]        rk_rd_data
);

    ks_state_t   state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  p_q, p_d;
    logic [3:0]  rcon_idx_q, rcon_idx_d;
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic [5:0]  nwords_q, nwords_d;
    logic        key_err_q;
    logic [127:0] rk_rd_data_q;

    // 64 entries so any 6-bit index, including the 4*idx+3 read, stays in range.
    word_t       w_q [64];

    logic        load_ok;
    logic        load_bad;
    logic        gen_we;
    logic        len_ok;
    logic [3:0]  nk_new;
    word_t       w_new;
    logic [5:0]  rd_base;
    logic        idx_ok;

    assign nk_new = nk_of(key_len);
    assign len_ok = (key_len != KEY_LEN_RSVD) && (int'(nk_new) <= MAX_NK);

    key_word_gen u_word_gen (
        .w_prev_i (w_q[i_q - 6'd1]),
        .w_back_i (w_q[i_q - 6'(nk_q)]),
        .p_i      (p_q),
        .nk_i     (nk_q),
        .rcon_i   (rcon_of(rcon_idx_q)),
        .w_new_o  (w_new)
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        p_d        = p_q;
        rcon_idx_d = rcon_idx_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        nwords_d   = nwords_q;
        load_ok    = 1'b0;
        load_bad   = 1'b0;
        gen_we     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_key) begin
                    if (len_ok) begin
                        load_ok    = 1'b1;
                        state_d    = ST_GEN;
                        nk_d       = nk_new;
                        nr_d       = nr_of(key_len);
                        nwords_d   = nwords_of(key_len);
                        i_d        = 6'(nk_new);
                        p_d        = 3'd0;
                        rcon_idx_d = 4'd1;
                    end else begin
                        load_bad = 1'b1;
                    end
                end
            end
            ST_GEN: begin
                gen_we = 1'b1;
                i_d    = i_q + 6'd1;
                if (p_q == 3'(nk_q - 4'd1)) begin
                    p_d        = 3'd0;
                    rcon_idx_d = rcon_idx_q + 4'd1;
                end else begin
                    p_d = p_q + 3'd1;
                end
                if (i_q == (nwords_q - 6'd1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            p_q        <= '0;
            rcon_idx_q <= '0;
            nk_q       <= '0;
            nr_q       <= '0;
            nwords_q   <= '0;
            key_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            p_q        <= p_d;
            rcon_idx_q <= rcon_idx_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            nwords_q   <= nwords_d;
            key_err_q  <= load_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) begin
                w_q[k] <= '0;
            end
        end else if (load_ok) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(nk_new)) begin
                    w_q[k] <= key_in[255 - 32*k -: 32];
                end
            end
        end else if (gen_we) begin
            w_q[i_q] <= w_new;
        end
    end

    assign rd_base = {rk_rd_idx[3:0], 2'b00};
    assign idx_ok  = keys_ready && (32'(rk_rd_idx) <= 32'(nr_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_rd_data_q <= '0;
        end else if (idx_ok) begin
            rk_rd_data_q <= {w_q[rd_base], w_q[rd_base + 6'd1],
                             w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
        end else begin
            rk_rd_data_q <= '0;
        end
    end

    assign busy       = (state_q == ST_GEN);
    assign keys_ready = (state_q == ST_DONE);
    assign key_err    = key_err_q;
    assign nr         = nr_q;
    assign rk_rd_data = rk_rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_key_sched_multi.sv
// ============================================================================
//  Module   : tb_key_sched_multi
//  Purpose  : Self-checking bench for key_sched_multi against a behavioural
//             AES key-expansion model (GF-derived S-box, modulo indexing).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_sched_multi;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_key;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         keys_ready;
    logic         key_err;
    logic [3:0]   nr;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  sb    [256];
    logic [31:0] ref_w [60];

    key_sched_multi #(.MAX_NK(8), .RK_IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_key   (load_key),
        .key_len    (key_len),
        .key_in     (key_in),
        .busy       (busy),
        .keys_ready (keys_ready),
        .key_err    (key_err),
        .nr         (nr),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // S-box from its algebraic definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [255:0] key, input int mode);
        int nk;
        int total;
        logic [7:0]  rc;
        logic [31:0] t;
        nk    = 4 + 2*mode;
        total = 4 * (nk + 7);
        rc    = 8'h01;
        for (int i = 0; i < 60; i++) ref_w[i] = 32'h0;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads a key and counts edges after the load edge until keys_ready rises.
    task automatic load_and_wait(input logic [255:0] key, input logic [1:0] len, output int edges);
        key_in   = key;
        key_len  = len;
        load_key = 1'b1;
        tick();
        load_key = 1'b0;
        edges    = 0;
        while (!keys_ready && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    task automatic read_rk(input int r);
        rk_rd_idx = 4'(r);
        tick();
    endtask

    task automatic check_all_rk(input string tag, input int nrr);
        for (int r = 0; r <= nrr + 1 && r < 16; r++) begin
            read_rk(r);
            chk_val($sformatf("%s_rk%0d", tag, r), rk_rd_data,
                    (r <= nrr) ? ref_rk(r) : 128'h0);
        end
    endtask

    localparam logic [255:0] c_K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] c_K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] c_K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        int edges;
        int mode;
        logic [255:0] rkey;

        rst       = 1'b1;
        load_key  = 1'b0;
        key_len   = 2'd0;
        key_in    = '0;
        rk_rd_idx = 4'd0;
        build_sbox();
        #12;
        chk_val("rst_busy",  128'(busy),       128'(0));
        chk_val("rst_ready", 128'(keys_ready), 128'(0));
        chk_val("rst_err",   128'(key_err),    128'(0));
        chk_val("rst_nr",    128'(nr),         128'(0));
        chk_val("rst_rd",    rk_rd_data,       128'h0);
        rst = 1'b0;
        tick();

        // Reserved length from IDLE
        key_len  = 2'd3;
        load_key = 1'b1;
        tick();
        load_key = 1'b0;
        chk_val("idle_rej_err",  128'(key_err), 128'(1));
        chk_val("idle_rej_busy", 128'(busy),    128'(0));
        chk_val("idle_rej_nr",   128'(nr),      128'(0));
        tick();
        chk_val("idle_rej_err_off", 128'(key_err), 128'(0));

        // AES-128 known answer
        model_expand(c_K128, 0);
        load_and_wait(c_K128, 2'd0, edges);
        chk_val("k128_latency", 128'(edges), 128'(40));
        chk_val("k128_nr", 128'(nr), 128'(10));
        read_rk(0);
        chk_val("k128_rk0", rk_rd_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_rk(10);
        chk_val("k128_rk10", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_all_rk("k128", 10);

        // Reserved length while DONE: one pulse, keys retained
        key_len  = 2'd3;
        key_in   = c_K256;
        load_key = 1'b1;
        rk_rd_idx = 4'd10;
        tick();
        load_key = 1'b0;
        chk_val("done_rej_err",   128'(key_err),    128'(1));
        chk_val("done_rej_ready", 128'(keys_ready), 128'(1));
        chk_val("done_rej_nr",    128'(nr),         128'(10));
        tick();
        chk_val("done_rej_err_off", 128'(key_err), 128'(0));
        chk_val("done_rej_rk10", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192 known answer
        model_expand(c_K192, 1);
        load_and_wait(c_K192, 2'd1, edges);
        chk_val("k192_latency", 128'(edges), 128'(46));
        chk_val("k192_nr", 128'(nr), 128'(12));
        read_rk(12);
        chk_val("k192_rk12", rk_rd_data, 128'he98ba06f448c773c8ecc720401002202);
        read_rk(13);
        chk_val("k192_rk13", rk_rd_data, 128'h0);
        check_all_rk("k192", 12);

        // AES-256 known answer
        model_expand(c_K256, 2);
        load_and_wait(c_K256, 2'd2, edges);
        chk_val("k256_latency", 128'(edges), 128'(52));
        chk_val("k256_nr", 128'(nr), 128'(14));
        read_rk(14);
        chk_val("k256_rk14", rk_rd_data, 128'hfe4890d1e6188d0b046df344706c631e);
        check_all_rk("k256", 14);

        // Asynchronous reset at edge 20 of an AES-256 expansion
        key_in   = c_K256;
        key_len  = 2'd2;
        load_key = 1'b1;
        tick();
        load_key = 1'b0;
        chk_val("gen_ready_low", 128'(keys_ready), 128'(0));
        rk_rd_idx = 4'd0;
        for (int k = 0; k < 20; k++) tick();
        chk_val("mid_busy", 128'(busy), 128'(1));
        chk_val("mid_rd_zero", rk_rd_data, 128'h0);
        rst = 1'b1;
        #1;
        chk_val("arst_busy",  128'(busy),       128'(0));
        chk_val("arst_ready", 128'(keys_ready), 128'(0));
        chk_val("arst_nr",    128'(nr),         128'(0));
        chk_val("arst_rd",    rk_rd_data,       128'h0);
        #2;
        rst = 1'b0;
        model_expand(c_K128, 0);
        load_and_wait(c_K128, 2'd0, edges);
        chk_val("post_rst_latency", 128'(edges), 128'(40));
        check_all_rk("post_rst", 10);

        // A second load during GEN is ignored
        rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        model_expand(rkey, 2);
        key_in   = rkey;
        key_len  = 2'd2;
        load_key = 1'b1;
        tick();
        load_key = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        key_in   = ~rkey;
        key_len  = 2'd0;
        load_key = 1'b1;
        tick();
        load_key = 1'b0;
        chk_val("ign_err",  128'(key_err), 128'(0));
        chk_val("ign_busy", 128'(busy),    128'(1));
        edges = 5;
        while (!keys_ready && edges < 100) begin
            tick();
            edges++;
        end
        chk_val("ign_latency", 128'(edges), 128'(52));
        chk_val("ign_nr", 128'(nr), 128'(14));
        check_all_rk("ign", 14);

        // Randomised keys and modes
        for (int t = 0; t < 6; t++) begin
            mode = int'($urandom_range(0, 2));
            rkey = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(rkey, mode);
            load_and_wait(rkey, 2'(mode), edges);
            chk_val($sformatf("rnd%0d_latency", t), 128'(edges), 128'(4*(4 + 2*mode + 7) - (4 + 2*mode)));
            chk_val($sformatf("rnd%0d_nr", t), 128'(nr), 128'(10 + 2*mode));
            check_all_rk($sformatf("rnd%0d", t), 10 + 2*mode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
